// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encoding and parameter check for serial_adder
//
// Purpose : state encoding for the serial adder FSM and an elaboration-time
//           helper that validates the WIDTH/DIGIT pairing.
// Ports   : none (package).
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True when DIGIT slices WIDTH into a whole number of digits.
   function automatic bit digit_divides(input int width, input int digit);
      return (width >= 1) && (digit >= 1) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/adder_digit.sv
// rtl/adder_digit.sv - DIGIT-bit combinational ripple slice
//
// Purpose : ripple chain of full_adder_df cells, reused every RUN cycle.
// Ports   : a, b     - DIGIT-bit addend digits
//           ci       - carry into bit 0 of the digit
//           s        - DIGIT-bit digit sum
//           co       - carry out of the digit MSB
//           c_msb_in - carry into the digit MSB (signed overflow detection)
module adder_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      full_adder_df u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co       = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/full_adder_df.sv
// rtl/full_adder_df.sv - single-bit dataflow full adder cell
//
// Purpose : one-bit full adder, the building block of the digit slice.
// Ports   : a, b, ci - addend bits and carry in
//           s        - sum bit
//           co       - carry out
module full_adder_df (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial WIDTH-bit adder with start/done handshake
//
// Purpose : adds a + b + cin, DIGIT bits per clock, reusing one adder_digit
//           slice with a registered carry between digits.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           start - request, accepted in IDLE or DONE
//           a, b  - WIDTH-bit operands, captured on accept
//           cin   - carry in, captured on accept
//           busy  - high while running
//           done  - one-cycle pulse when sum/cout become valid
//           sum   - (a + b + cin) mod 2^WIDTH, held until the next result
//           cout  - carry out of bit WIDTH-1
//           ovf   - signed overflow (only with SERIAL_ADDER_OVF_EN defined)
// Macro   : SERIAL_ADDER_OVF_EN adds the ovf output and its register.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (!digit_divides(WIDTH, DIGIT)) begin : g_bad_cfg
      $fatal(1, "serial_adder: DIGIT must divide WIDTH");
   end

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
   logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
   logic               carry_q,  carry_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0]   res_q,    res_d;
   logic [WIDTH-1:0]   sum_q,    sum_d;
   logic               cout_q,   cout_d;

   logic [DIGIT-1:0]   dig_s;
   logic               dig_co;
   logic [WIDTH-1:0]   res_next;
   logic               last_digit;

`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q,    ovf_d;
   logic               dig_c_msb_in;
`else
   logic               unused_c_msb_in;
`endif

   adder_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a        (a_sh_q[DIGIT-1:0]),
      .b        (b_sh_q[DIGIT-1:0]),
      .ci       (carry_q),
      .s        (dig_s),
      .co       (dig_co),
`ifdef SERIAL_ADDER_OVF_EN
      .c_msb_in (dig_c_msb_in)
`else
      .c_msb_in (unused_c_msb_in)
`endif
   );

   // New digit enters at the MSB end; after NDIG shifts the first digit
   // has walked down to sum[DIGIT-1:0].
   assign res_next   = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
   assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> DIGIT;
            b_sh_d  = b_sh_q >> DIGIT;
            carry_d = dig_co;
            cnt_d   = cnt_q + CNT_W'(1);
            res_d   = res_next;
            // Visible result changes only on the way into DONE, so the
            // previous sum stays readable for the whole run.
            if (last_digit) begin
               state_d = DONE;
               sum_d   = res_next;
               cout_d  = dig_co;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = dig_co ^ dig_c_msb_in;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (four configurations)
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic       rst_in   [4];
   logic       start_in [4];
   logic       cin_in   [4];
   logic [7:0] a_in     [4];
   logic [7:0] b_in     [4];
   logic       busy_o   [4];
   logic       done_o   [4];
   logic       cout_o   [4];
   logic [7:0] sum_o    [4];
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf_o    [4];
`endif

   task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cfg%0d t=%0t: got 0x%0h, expected 0x%0h", name, g, $time, act, exp);
      end
   endtask

   function automatic int width_of(input int g);
      return (g < 2) ? 8 : 4;
   endfunction

   function automatic int ndig_of(input int g);
      case (g)
         0:       return 8;
         1:       return 2;
         2:       return 4;
         default: return 2;
      endcase
   endfunction

   // Configurations: 0 = W8/D1, 1 = W8/D4, 2 = W4/D1, 3 = W4/D2
   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int W = (g < 2) ? 8 : 4;
      localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 1 : 2;
      localparam int N = W / D;

      logic         rst_l, busy, done, cout;
      logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
      logic         ovf;
`endif

      assign rst_l = rst_in[g];

      serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
         .clk   (clk),
         .rst_n (rst_l),
         .start (start_in[g]),
         .a     (a_in[g][W-1:0]),
         .b     (b_in[g][W-1:0]),
         .cin   (cin_in[g]),
         .busy  (busy),
         .done  (done),
         .sum   (sum),
         .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
         ,
         .ovf   (ovf)
`endif
      );

      assign busy_o[g] = busy;
      assign done_o[g] = done;
      assign cout_o[g] = cout;
      assign sum_o[g]  = 8'(sum);
`ifdef SERIAL_ADDER_OVF_EN
      assign ovf_o[g]  = ovf;
`endif

      // Transaction-level model: an accepted request yields its answer
      // exactly N edges later; requests while an answer is pending are dropped.
      int       m_left;
      logic     m_busy, m_done, m_cout, m_ovf;
      logic [W-1:0] m_sum;
      int       p_total;
      logic     p_ovf;

      always @(posedge clk or negedge rst_l) begin
         if (!rst_l) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
         end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_busy <= (m_left != 1);
            m_done <= (m_left == 1);
            if (m_left == 1) begin
               m_sum  <= W'(p_total);
               m_cout <= 1'((p_total >> W) & 1);
               m_ovf  <= p_ovf;
            end
         end else begin
            m_done <= 1'b0;
            if (start_in[g]) begin
               p_total <= int'(a_in[g][W-1:0]) + int'(b_in[g][W-1:0]) + int'(cin_in[g]);
               p_ovf   <= (a_in[g][W-1] == b_in[g][W-1]) &&
                          (1'(((int'(a_in[g][W-1:0]) + int'(b_in[g][W-1:0]) + int'(cin_in[g])) >> (W-1)) & 1) != a_in[g][W-1]);
               m_left  <= N;
               m_busy  <= 1'b1;
            end
         end
      end

      always @(negedge clk) begin
         check("busy", g, busy, m_busy);
         check("done", g, done, m_done);
         check("sum",  g, 32'(sum), 32'(m_sum));
         check("cout", g, cout, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
         check("ovf",  g, ovf, m_ovf);
`endif
      end
   end

   task automatic run_op(input int g, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit noise, output int lat, output int nbusy, output logic [8:0] res);
      @(negedge clk);
      a_in[g] = a; b_in[g] = b; cin_in[g] = c; start_in[g] = 1'b1;
      @(negedge clk);
      start_in[g] = 1'b0;
      a_in[g] = 8'($urandom); b_in[g] = 8'($urandom); cin_in[g] = 1'($urandom);
      lat = 0; nbusy = 0;
      while (!done_o[g] && lat < 64) begin
         if (busy_o[g]) nbusy++;
         start_in[g] = noise ? 1'($urandom) : 1'b0;
         @(negedge clk);
         lat++;
      end
      start_in[g] = 1'b0;
      if (!done_o[g]) check("done_timeout", g, 0, 1);
      res = {cout_o[g], sum_o[g]};
   endtask

   function automatic logic [8:0] expect_res(input int g, input int a, input int b, input int c);
      int s, w;
      w = width_of(g);
      s = a + b + c;
      return 9'(((s >> w) << 8) | (s & ((1 << w) - 1)));
   endfunction

   int lat, nbusy, k, dcount;
   logic [8:0] res;
   logic [7:0] ra, rb;
   logic rc;

   initial begin
      for (int i = 0; i < 4; i++) begin
         rst_in[i] = 1'b0; start_in[i] = 1'b0; cin_in[i] = 1'b0;
         a_in[i] = 8'h00;  b_in[i] = 8'h00;
      end
      repeat (2) @(negedge clk);
      check("reset_busy", 0, busy_o[0], 0);
      check("reset_done", 0, done_o[0], 0);
      check("reset_sum",  0, 32'(sum_o[0]), 0);
      check("reset_cout", 0, cout_o[0], 0);
      for (int i = 0; i < 4; i++) rst_in[i] = 1'b1;

      // Basic: FF + 01
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, lat, nbusy, res);
      check("basic_latency", 0, lat, 8);
      check("basic_busy_cycles", 0, nbusy, 8);
      check("basic_result", 0, 32'(res), 32'h100);
      @(negedge clk);
      check("done_single_pulse", 0, done_o[0], 0);
      check("idle_after_done", 0, busy_o[0], 0);

      // Carry-in: 7F + 00 + 1
      run_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, lat, nbusy, res);
      check("cin_result", 0, 32'(res), 32'h080);
`ifdef SERIAL_ADDER_OVF_EN
      check("cin_ovf", 0, ovf_o[0], 1);
`endif

      // Reset mid-operation
      @(negedge clk);
      a_in[0] = 8'hFF; b_in[0] = 8'h01; cin_in[0] = 1'b0; start_in[0] = 1'b1;
      @(negedge clk);
      start_in[0] = 1'b0;
      repeat (2) @(negedge clk);
      check("midop_busy_before", 0, busy_o[0], 1);
      rst_in[0] = 1'b0;
      #1;
      check("midop_busy", 0, busy_o[0], 0);
      check("midop_done", 0, done_o[0], 0);
      check("midop_sum",  0, 32'(sum_o[0]), 0);
      check("midop_cout", 0, cout_o[0], 0);
      @(negedge clk);
      rst_in[0] = 1'b1;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_o[0]) dcount++;
      end
      check("midop_no_done", 0, dcount, 0);

      // DIGIT=4
      run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, lat, nbusy, res);
      check("d4_latency", 1, lat, 2);
      check("d4_result", 1, 32'(res), 32'h100);

      // Back-to-back with a start ignored during RUN
      run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, lat, nbusy, res);
      check("b2b_first", 0, 32'(res), 32'h003);
      a_in[0] = 8'h10; b_in[0] = 8'h20; cin_in[0] = 1'b0; start_in[0] = 1'b1;
      @(negedge clk);
      start_in[0] = 1'b0;
      check("b2b_no_idle_busy", 0, busy_o[0], 1);
      check("b2b_no_idle_done", 0, done_o[0], 0);
      check("b2b_sum_held", 0, 32'(sum_o[0]), 32'h03);
      a_in[0] = 8'h55; b_in[0] = 8'h55; cin_in[0] = 1'b1; start_in[0] = 1'b1;
      @(negedge clk);
      start_in[0] = 1'b0;
      k = 0;
      while (!done_o[0] && k < 64) begin
         @(negedge clk);
         k++;
      end
      check("b2b_done_seen", 0, done_o[0], 1);
      check("b2b_second", 0, 32'({cout_o[0], sum_o[0]}), 32'h030);

      // Randomized on the 8-bit configurations, with stray starts while busy
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 120; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run_op(g, ra, rb, rc, 1'b1, lat, nbusy, res);
            check("rand_latency", g, lat, ndig_of(g));
            check("rand_result", g, 32'(res), 32'(expect_res(g, int'(ra), int'(rb), int'(rc))));
         end
      end

      // Exhaustive on the 4-bit configurations
      for (int g = 2; g < 4; g++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               for (int c = 0; c < 2; c++) begin
                  run_op(g, 8'(x), 8'(y), 1'(c), 1'b0, lat, nbusy, res);
                  check("exh_latency", g, lat, ndig_of(g));
                  check("exh_result", g, 32'(res), 32'(expect_res(g, x, y, c)));
               end
            end
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
